// File: rtl/lsu_pkg.sv
// Shared definitions for the MEM-stage load/store initiator and its lane aligner.
//   - lsu_size_e  : access size codes as carried on mem_size
//   - lsu_state_e : initiator FSM states
//   - TIMEOUT_CYCLES_DEF : default WAIT-cycle budget before a request is abandoned
//   - access_legal() : alignment / size legality check
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } lsu_size_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    DONE = 2'b10
  } lsu_state_e;

  localparam int TIMEOUT_CYCLES_DEF = 255;

  // Half accesses need an even address, words need a 4-byte aligned address,
  // and the reserved size code is never legal.
  function automatic logic access_legal(input lsu_size_e size, input logic [1:0] off);
    logic ok;
    case (size)
      SZ_BYTE: ok = 1'b1;
      SZ_HALF: ok = ~off[0];
      SZ_WORD: ok = (off == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane steering between a 32-bit word bus and sub-word accesses.
// Store side: byte enables and lane replication of right-justified store data.
// Load side : lane extraction from a read word plus sign/zero extension.
// Ports:
//   st_size, st_off, st_data -> st_be, st_lanes   (store/request side)
//   ld_size, ld_off, ld_unsigned, ld_rdata -> ld_value (load return side)
module lsu_lane_align
  import lsu_pkg::*;
(
  input  lsu_size_e   st_size,
  input  logic [1:0]  st_off,
  input  logic [31:0] st_data,
  output logic [3:0]  st_be,
  output logic [31:0] st_lanes,
  input  lsu_size_e   ld_size,
  input  logic [1:0]  ld_off,
  input  logic        ld_unsigned,
  input  logic [31:0] ld_rdata,
  output logic [31:0] ld_value
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    st_be    = 4'b1111;
    st_lanes = st_data;
    case (st_size)
      SZ_BYTE: begin
        st_be    = 4'b0001 << st_off;
        st_lanes = {4{st_data[7:0]}};
      end
      SZ_HALF: begin
        st_be    = st_off[1] ? 4'b1100 : 4'b0011;
        st_lanes = {2{st_data[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    case (ld_off)
      2'd0:    ld_byte = ld_rdata[7:0];
      2'd1:    ld_byte = ld_rdata[15:8];
      2'd2:    ld_byte = ld_rdata[23:16];
      default: ld_byte = ld_rdata[31:24];
    endcase
    ld_half  = ld_off[1] ? ld_rdata[31:16] : ld_rdata[15:0];
    ld_value = ld_rdata;
    case (ld_size)
      SZ_BYTE: ld_value = ld_unsigned ? {24'b0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      SZ_HALF: ld_value = ld_unsigned ? {16'b0, ld_half} : {{16{ld_half[15]}}, ld_half};
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu_mem_initiator.sv
// MEM-stage load/store initiator: turns lb/lbu/lh/lhu/lw/sb/sh/sw into word-aligned
// data-memory requests with byte enables, stalls the pipeline while the request is
// outstanding, and returns the extended load result.
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   MemRead, MemWrite, mem_size,     access request from the MEM stage
//   mem_unsigned, MEM_ALU, MEM_WriteData
//   dm_req/dm_we/dm_be/dm_addr/dm_wdata  registered request to memory
//   dm_rdata, dm_ready               memory response
//   stall                            combinational pipeline hold
//   load_data                        extended load result (held)
//   done, misalign_exc, bus_err      one-cycle status pulses
// Handshake: dm_req rises the cycle after a legal access is accepted and every dm_*
// output stays stable while dm_req is high; a cycle in WAIT with dm_ready=1 completes
// the transfer and dm_req drops on the following edge. dm_ready is ignored elsewhere.
// The FSM state is the internal signal `state` (lsu_state_e).
module lsu_mem_initiator
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int CNT_W          = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [1:0]  mem_size,
  input  logic        mem_unsigned,
  input  logic [31:0] MEM_ALU,
  input  logic [31:0] MEM_WriteData,
  output logic        dm_req,
  output logic        dm_we,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  input  logic [31:0] dm_rdata,
  input  logic        dm_ready,
  output logic        stall,
  output logic [31:0] load_data,
  output logic        done,
  output logic        misalign_exc,
  output logic        bus_err
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  lsu_state_e       state, state_next;
  logic [CNT_W-1:0] cnt;

  // Attributes of the outstanding access needed when the data returns.
  logic [1:0]       lat_off;
  lsu_size_e        lat_size;
  logic             lat_unsigned;

  lsu_size_e        req_size;
  logic             start, legal;
  logic             issue, misalign, complete, timeout;
  logic [3:0]       be_new;
  logic [31:0]      lanes_new, ld_value;

  assign req_size = lsu_size_e'(mem_size);
  assign start    = MemRead | MemWrite;
  assign legal    = access_legal(req_size, MEM_ALU[1:0]);

  lsu_lane_align u_lane_align (
    .st_size     (req_size),
    .st_off      (MEM_ALU[1:0]),
    .st_data     (MEM_WriteData),
    .st_be       (be_new),
    .st_lanes    (lanes_new),
    .ld_size     (lat_size),
    .ld_off      (lat_off),
    .ld_unsigned (lat_unsigned),
    .ld_rdata    (dm_rdata),
    .ld_value    (ld_value)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    stall      = 1'b0;
    issue      = 1'b0;
    misalign   = 1'b0;
    complete   = 1'b0;
    timeout    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (legal) begin
            stall      = 1'b1;
            issue      = 1'b1;
            state_next = WAIT;
          end else begin
            misalign = 1'b1;
          end
        end
      end
      WAIT: begin
        stall = 1'b1;
        // A response on the last budgeted cycle still counts as success.
        if (dm_ready) begin
          complete   = 1'b1;
          state_next = DONE;
        end else if (cnt == CNT_LAST) begin
          timeout    = 1'b1;
          state_next = DONE;
        end
      end
      // The pipeline advances on this edge; the still-visible old instruction
      // must not be issued a second time, so inputs are ignored here.
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dm_req       <= 1'b0;
      dm_we        <= 1'b0;
      dm_be        <= 4'b0;
      dm_addr      <= 32'b0;
      dm_wdata     <= 32'b0;
      load_data    <= 32'b0;
      done         <= 1'b0;
      misalign_exc <= 1'b0;
      bus_err      <= 1'b0;
      cnt          <= '0;
      lat_off      <= 2'b0;
      lat_size     <= SZ_BYTE;
      lat_unsigned <= 1'b0;
    end else begin
      done         <= 1'b0;
      misalign_exc <= misalign;
      bus_err      <= 1'b0;

      if (issue) begin
        dm_req       <= 1'b1;
        dm_we        <= MemWrite;  // store wins when both requests are high
        dm_be        <= be_new;
        dm_addr      <= {MEM_ALU[31:2], 2'b00};
        dm_wdata     <= lanes_new;
        lat_off      <= MEM_ALU[1:0];
        lat_size     <= req_size;
        lat_unsigned <= mem_unsigned;
      end

      if (complete) begin
        dm_req <= 1'b0;
        done   <= 1'b1;
        if (!dm_we) load_data <= ld_value;
      end

      if (timeout) begin
        dm_req  <= 1'b0;
        done    <= 1'b1;
        bus_err <= 1'b1;
        if (!dm_we) load_data <= 32'b0;
      end

      if (state == WAIT)      cnt <= cnt + 1'b1;
      else if (state == DONE) cnt <= '0;
    end
  end

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Directed bench for lsu_mem_initiator, built with a 4-cycle timeout budget.
module tb_lsu_mem_initiator;
  import lsu_pkg::*;

  localparam int TMO = 4;

  logic        clk;
  logic        rst_n;
  logic        MemRead, MemWrite, mem_unsigned;
  logic [1:0]  mem_size;
  logic [31:0] MEM_ALU, MEM_WriteData;
  logic        dm_req, dm_we;
  logic [3:0]  dm_be;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic        dm_ready;
  logic        stall;
  logic [31:0] load_data;
  logic        done, misalign_exc, bus_err;

  int n_vec  = 0;
  int n_miss = 0;
  logic [31:0] exp_q[$];

  lsu_mem_initiator #(.TIMEOUT_CYCLES(TMO), .CNT_W(8)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .MemRead       (MemRead),
    .MemWrite      (MemWrite),
    .mem_size      (mem_size),
    .mem_unsigned  (mem_unsigned),
    .MEM_ALU       (MEM_ALU),
    .MEM_WriteData (MEM_WriteData),
    .dm_req        (dm_req),
    .dm_we         (dm_we),
    .dm_be         (dm_be),
    .dm_addr       (dm_addr),
    .dm_wdata      (dm_wdata),
    .dm_rdata      (dm_rdata),
    .dm_ready      (dm_ready),
    .stall         (stall),
    .load_data     (load_data),
    .done          (done),
    .misalign_exc  (misalign_exc),
    .bus_err       (bus_err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, want %h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    MemRead       = 1'b0;
    MemWrite      = 1'b0;
    mem_size      = 2'b00;
    mem_unsigned  = 1'b0;
    MEM_ALU       = 32'h0;
    MEM_WriteData = 32'h0;
    dm_ready      = 1'b0;
    dm_rdata      = 32'h0;
  endtask

  // Legal access. lat = WAIT cycle (1-based) on which dm_ready is given, 0 = never.
  task automatic access(input string nm, input logic rd, input logic wr,
                        input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input int lat, input logic [31:0] rdata,
                        input logic [3:0] exp_be, input logic [31:0] exp_wd,
                        input logic [31:0] exp_ld, input logic exp_berr);
    int stall_cnt;
    int n_wait;
    MemRead = rd; MemWrite = wr; mem_size = sz; mem_unsigned = uns;
    MEM_ALU = addr; MEM_WriteData = wd; dm_ready = 1'b0;
    #1;
    stall_cnt = 0;
    if (stall) stall_cnt++;
    exp_q.push_back(exp_ld);
    @(posedge clk); #1;
    check({nm, "_req"}, dm_req, 1'b1);
    check({nm, "_addr"}, dm_addr, {addr[31:2], 2'b00});
    check({nm, "_be"}, dm_be, exp_be);
    check({nm, "_we"}, dm_we, wr);
    if (wr) check({nm, "_wdata"}, dm_wdata, exp_wd);
    n_wait = (lat == 0 || lat > TMO) ? TMO : lat;
    for (int i = 0; i < n_wait; i++) begin
      dm_ready = (lat != 0) && (i == n_wait - 1);
      dm_rdata = dm_ready ? rdata : 32'hA5A5_5A5A;
      if (stall) stall_cnt++;
      @(posedge clk); #1;
    end
    dm_ready = 1'b0;
    dm_rdata = 32'hFFFF_FFFF;
    check({nm, "_done"}, done, 1'b1);
    check({nm, "_berr"}, bus_err, exp_berr);
    check({nm, "_req_drop"}, dm_req, 1'b0);
    check({nm, "_stall_done"}, stall, 1'b0);
    check({nm, "_stall_cyc"}, stall_cnt, 1 + n_wait);
    check({nm, "_load"}, load_data, exp_q.pop_front());
    @(posedge clk); #1;
    idle_inputs();
    check({nm, "_done_pulse"}, done, 1'b0);
    check({nm, "_no_reissue"}, dm_req, 1'b0);
  endtask

  task automatic misaligned(input string nm, input logic wr, input logic [1:0] sz,
                            input logic [31:0] addr);
    MemRead = ~wr; MemWrite = wr; mem_size = sz; mem_unsigned = 1'b0;
    MEM_ALU = addr; MEM_WriteData = 32'h1111_2222;
    #1;
    check({nm, "_stall"}, stall, 1'b0);
    @(posedge clk); #1;
    check({nm, "_exc"}, misalign_exc, 1'b1);
    check({nm, "_req"}, dm_req, 1'b0);
    check({nm, "_state"}, 32'(dut.state), 32'(IDLE));
    idle_inputs();
    @(posedge clk); #1;
    check({nm, "_exc_pulse"}, misalign_exc, 1'b0);
    check({nm, "_req2"}, dm_req, 1'b0);
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req", dm_req, 1'b0);
    check("rst_we", dm_we, 1'b0);
    check("rst_be", dm_be, 4'b0);
    check("rst_addr", dm_addr, 32'h0);
    check("rst_wdata", dm_wdata, 32'h0);
    check("rst_load", load_data, 32'h0);
    check("rst_done", done, 1'b0);
    check("rst_exc", misalign_exc, 1'b0);
    check("rst_berr", bus_err, 1'b0);
    check("rst_stall", stall, 1'b0);
    check("rst_state", 32'(dut.state), 32'(IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    //     name   rd    wr    size   uns   addr          wdata         lat rdata         be       exp_wdata     exp_load      berr
    access("lw",  1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0,        3, 32'hDEAD_BEEF, 4'b1111, 32'h0,        32'hDEAD_BEEF, 1'b0);
    access("lb",  1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_0013, 32'h0,        2, 32'h80FF_0000, 4'b1000, 32'h0,        32'hFFFF_FF80, 1'b0);
    access("lbu", 1'b1, 1'b0, 2'b00, 1'b1, 32'h0000_0013, 32'h0,        1, 32'h80FF_0000, 4'b1000, 32'h0,        32'h0000_0080, 1'b0);
    access("sh",  1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_0022, 32'h0000_ABCD, 2, 32'h1234_5678, 4'b1100, 32'hABCD_ABCD, 32'h0000_0080, 1'b0);
    access("lh",  1'b1, 1'b0, 2'b01, 1'b0, 32'h0000_0002, 32'h0,        1, 32'h8001_7FFF, 4'b1100, 32'h0,        32'hFFFF_8001, 1'b0);
    access("lhu_edge", 1'b1, 1'b0, 2'b01, 1'b1, 32'h0000_0002, 32'h0,   4, 32'h8001_7FFF, 4'b1100, 32'h0,        32'h0000_8001, 1'b0);
    access("sb_rw", 1'b1, 1'b1, 2'b00, 1'b0, 32'h0000_0001, 32'h1234_5678, 1, 32'hFFFF_FFFF, 4'b0010, 32'h7878_7878, 32'h0000_8001, 1'b0);
    access("lbu1", 1'b1, 1'b0, 2'b00, 1'b1, 32'h0000_0001, 32'h0,       2, 32'h0000_C300, 4'b0010, 32'h0,        32'h0000_00C3, 1'b0);
    access("sw",  1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_0040, 32'hCAFE_F00D, 1, 32'h0,        4'b1111, 32'hCAFE_F00D, 32'h0000_00C3, 1'b0);
    access("tmo", 1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0000, 32'h0,        0, 32'h0,         4'b1111, 32'h0,        32'h0,         1'b1);

    misaligned("ma_lw",  1'b0, 2'b10, 32'h0000_0006);
    misaligned("ma_lh",  1'b0, 2'b01, 32'h0000_0003);
    misaligned("ma_rsv", 1'b0, 2'b11, 32'h0000_0000);
    misaligned("ma_sw",  1'b1, 2'b10, 32'h0000_0041);

    // reset in the middle of WAIT
    MemRead = 1'b1; mem_size = 2'b10; MEM_ALU = 32'h0000_0008;
    @(posedge clk); #1;
    idle_inputs();
    check("mid_req", dm_req, 1'b1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_req", dm_req, 1'b0);
    check("mid_rst_state", 32'(dut.state), 32'(IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    access("post_rst", 1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0008, 32'h0, 1, 32'h1234_5678, 4'b1111, 32'h0, 32'h1234_5678, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/lsu_mem_initiator.md
Name: lsu_mem_initiator

Overview:
- Load/store initiator for the MEM stage of the pipelined MIPS datapath; the requesting side of the data-memory interface.
- Converts lb/lbu/lh/lhu/lw/sb/sh/sw into word-aligned memory requests with byte enables, using a req/ready handshake.
- Stalls the pipeline while a request is outstanding, then returns a sign- or zero-extended load result.
- Flags misaligned accesses and memory timeouts.

Parameters:
- TIMEOUT_CYCLES, 255: maximum WAIT cycles before the request is abandoned. Range 1..255.
- CNT_W, 8: width of the timeout counter.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst_n  input  1  asynchronous reset, active-low.
- MemRead  input  1  load request from the MEM stage.
- MemWrite  input  1  store request from the MEM stage.
- mem_size  input  2  access size: 00 byte, 01 half, 10 word, 11 reserved.
- mem_unsigned  input  1  load extension: 1 zero-extend, 0 sign-extend.
- MEM_ALU  input  32  effective byte address.
- MEM_WriteData  input  32  store data, right-justified.
- dm_req  output  1  request valid to memory.
- dm_we  output  1  1 store, 0 load.
- dm_be  output  4  byte enables; bit k selects bits 8k+7:8k.
- dm_addr  output  32  word address, bits [1:0] always 0.
- dm_wdata  output  32  store data lane-replicated.
- dm_rdata  input  32  read data; valid when dm_ready=1.
- dm_ready  input  1  memory completes the request this cycle.
- stall  output  1  combinational; pipeline holds MEM inputs while high.
- load_data  output  32  extended load result; held until the next load completes.
- done  output  1  one-cycle pulse when an access completes.
- misalign_exc  output  1  one-cycle pulse on a misaligned or reserved-size access.
- bus_err  output  1  one-cycle pulse on timeout.

Behaviour:
- Reset: state IDLE; all registered outputs 0 (dm_req, dm_we, dm_be, dm_addr, dm_wdata, load_data, done, misalign_exc, bus_err); counter 0. Reset during WAIT abandons the access and drops dm_req asynchronously.
- start = MemRead | MemWrite. If both are high, the access is a store; no read is issued.
- Alignment: half requires MEM_ALU[0]=0; word requires MEM_ALU[1:0]=00; size 11 is always illegal.
- States: IDLE, WAIT, DONE.
- IDLE, start and illegal access:
  - misalign_exc=1 next cycle; no memory request; stall stays 0; remain IDLE.
- IDLE, start and legal access:
  - stall=1 in this cycle.
  - Latch dm_addr={MEM_ALU[31:2],2'b00}, dm_we, dm_be, dm_wdata; latch byte offset, size and unsigned flag for extraction.
  - Next cycle: dm_req=1, go to WAIT.
- WAIT:
  - stall=1; dm_req and all dm_* outputs held stable.
  - Counter increments each cycle.
  - dm_ready=1: drop dm_req next cycle; for loads, load_data <= extracted/extended dm_rdata; done=1 next cycle; go to DONE.
  - Zero-wait memory (dm_ready=1 in the first WAIT cycle) is legal.
  - If the counter reaches TIMEOUT_CYCLES-1 without dm_ready: drop dm_req; bus_err=1 and done=1 next cycle; load_data <= 0 for loads; go to DONE.
  - dm_ready and timeout in the same cycle: dm_ready wins.
- DONE:
  - stall=0, so the pipeline advances at this edge.
  - Inputs are ignored, which prevents a duplicate issue of the held instruction.
  - Clear the counter; go to IDLE.
- Byte enables:
  - byte: be = 1 << addr[1:0].
  - half: addr[1]=0 gives 0011, 1 gives 1100.
  - word: 1111.
- Store lane replication:
  - byte: {4{wd[7:0]}}.
  - half: {2{wd[15:0]}}.
  - word: wd.
- Load extraction:
  - byte: rdata[8k+7:8k], k = addr[1:0].
  - half: rdata[16h+15:16h], h = addr[1].
  - Extend to 32 bits per mem_unsigned.
  - Stores do not modify load_data.
- Memory rule: dm_ready is ignored outside WAIT.

Decomposition:
- Shared package lsu_pkg:
  - size codes SZ_BYTE, SZ_HALF, SZ_WORD;
  - FSM state enum;
  - TIMEOUT_CYCLES default.
- One natural combinational sub-module, lsu_lane_align: byte-enable generation, store replication, load extraction/extension. Reused by a future cache.

Test Plan:
- lw at 0x0000_0010, memory returns 0xDEADBEEF after 3 cycles -> dm_addr=0x10, be=1111, stall high 4 cycles, done pulse, load_data=0xDEADBEEF.
- lb at 0x13, rdata=0x80FF_0000, signed -> be=1000, load_data=0xFFFF_FF80; repeat as lbu -> 0x0000_0080.
- sh at 0x22 with data 0x0000_ABCD -> dm_we=1, be=1100, dm_wdata=0xABCD_ABCD, addr=0x20.
- lw at 0x0000_0006 -> misalign_exc pulse, dm_req never asserted, stall 0.
- TIMEOUT_CYCLES=4, dm_ready held 0 -> dm_req drops after 4 WAIT cycles, bus_err and done pulse, load_data=0.
- Assert rst_n low mid-WAIT -> dm_req=0 immediately, state IDLE; a subsequent lw completes normally.
